// File: rtl/timer_loader.sv
// MM:SS countdown register for the microwave: shifts in BCD keypad digits while idle,
// then counts down once per 1 Hz tick under start/stop/clear control.
module timer_loader (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] BCD_IN,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [15:0] r_time;
  logic [15:0] w_time_d;
  logic [15:0] w_time_dec;
  logic        r_loadn_q;
  logic        r_tick_q;
  logic        r_running;
  logic        r_done;
  logic        w_load;
  logic        w_tick;
  logic        w_zero;

  assign w_load = ~loadn & r_loadn_q;
  assign w_tick = pgt_1hz & ~r_tick_q;
  assign w_zero = (r_time == 16'h0000);

  // One-second BCD decrement; digits are taken as entered, so 0:99 counts 0:98, 0:97, ...
  always_comb begin
    logic [3:0] w_so, w_st, w_mo, w_mt;
    {w_mt, w_mo, w_st, w_so} = r_time;
    if (w_so != 4'd0) begin
      w_so = w_so - 4'd1;
    end else if (w_st != 4'd0) begin
      w_so = 4'd9;
      w_st = w_st - 4'd1;
    end else if ((w_mo != 4'd0) || (w_mt != 4'd0)) begin
      w_so = 4'd9;
      w_st = 4'd5;
      if (w_mo != 4'd0) begin
        w_mo = w_mo - 4'd1;
      end else begin
        w_mo = 4'd9;
        w_mt = w_mt - 4'd1;
      end
    end
    w_time_dec = {w_mt, w_mo, w_st, w_so};
  end

  // Priority: clearn > stopn > startn > tick > load.
  always_comb begin
    w_state_d = r_state;
    w_time_d  = r_time;
    if (!clearn) begin
      w_state_d = StIdle;
      w_time_d  = 16'h0000;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!stopn) begin
            w_state_d = StIdle;
          end else if (!startn) begin
            if (!w_zero) w_state_d = StRun;
          end else if (w_load && (BCD_IN <= 4'd9)) begin
            w_time_d = {r_time[11:0], BCD_IN};
          end
        end
        StRun: begin
          if (!stopn) begin
            w_state_d = StPause;
          end else if (w_tick) begin
            w_time_d = w_time_dec;
            if (w_time_dec == 16'h0000) w_state_d = StDone;
          end
        end
        StPause: begin
          if (stopn && !startn) w_state_d = StRun;
        end
        StDone: begin
          w_state_d = StDone;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_time    <= 16'h0000;
      r_loadn_q <= 1'b1;
      r_tick_q  <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_time    <= w_time_d;
      r_loadn_q <= loadn;
      r_tick_q  <= pgt_1hz;
      r_running <= (w_state_d == StRun);
      r_done    <= (w_state_d == StDone);
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = r_time;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_timer_loader.sv
// Directed bench for timer_loader: expected {MM:SS, running, done} pushed when stimulus is
// driven, popped and compared once the DUT has responded.
module tb_timer_loader;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] BCD_IN;
  logic       loadn, pgt_1hz, startn, stopn, clearn;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, done;

  timer_loader dut (
    .clk      (clk),
    .resetn   (resetn),
    .BCD_IN   (BCD_IN),
    .loadn    (loadn),
    .pgt_1hz  (pgt_1hz),
    .startn   (startn),
    .stopn    (stopn),
    .clearn   (clearn),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [17:0] w_obs;
  assign w_obs = {min_tens, min_ones, sec_tens, sec_ones, running, done};

  string       tag_q[$];
  logic [17:0] val_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic push_exp(input string tag, input logic [15:0] t, input logic r, input logic d);
    tag_q.push_back(tag);
    val_q.push_back({t, r, d});
  endtask

  task automatic check_out();
    string       tag;
    logic [17:0] e;
    n_checks++;
    if (val_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h, no expected entry", w_obs);
    end else begin
      tag = tag_q.pop_front();
      e   = val_q.pop_front();
      assert (w_obs === e) n_pass++;
      else $error("FAIL %s: observed time=%h run=%b done=%b expected time=%h run=%b done=%b",
                  tag, w_obs[17:2], w_obs[1], w_obs[0], e[17:2], e[1], e[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input string tag, input logic [3:0] d, input logic [15:0] t);
    BCD_IN = d;
    loadn  = 1'b0;
    push_exp(tag, t, 1'b0, 1'b0);
    step();
    check_out();
    loadn = 1'b1;
    step();
  endtask

  task automatic tick(input string tag, input logic [15:0] t, input logic r, input logic d);
    pgt_1hz = 1'b1;
    push_exp(tag, t, r, d);
    step();
    check_out();
    pgt_1hz = 1'b0;
    step();
  endtask

  task automatic start(input string tag, input logic [15:0] t, input logic r, input logic d);
    startn = 1'b0;
    push_exp(tag, t, r, d);
    step();
    check_out();
    startn = 1'b1;
    step();
  endtask

  task automatic clear(input string tag);
    clearn = 1'b0;
    push_exp(tag, 16'h0000, 1'b0, 1'b0);
    step();
    check_out();
    clearn = 1'b1;
    step();
  endtask

  initial begin
    resetn = 1'b0; BCD_IN = 4'd0; loadn = 1'b1; pgt_1hz = 1'b0;
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    #3;
    push_exp("reset", 16'h0000, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    resetn = 1'b1;
    step();

    // 1,3,0 then start and one tick
    press("key1", 4'd1, 16'h0001);
    press("key3", 4'd3, 16'h0013);
    press("key0", 4'd0, 16'h0130);
    start("start_0130", 16'h0130, 1'b1, 1'b0);
    tick("tick_0129", 16'h0129, 1'b1, 1'b0);
    clear("clear_run");

    // minute and ten-minute borrows
    press("k100a", 4'd1, 16'h0001);
    press("k100b", 4'd0, 16'h0010);
    press("k100c", 4'd0, 16'h0100);
    start("start_0100", 16'h0100, 1'b1, 1'b0);
    tick("tick_0059", 16'h0059, 1'b1, 1'b0);
    clear("clear_0059");
    press("k1000a", 4'd1, 16'h0001);
    press("k1000b", 4'd0, 16'h0010);
    press("k1000c", 4'd0, 16'h0100);
    press("k1000d", 4'd0, 16'h1000);
    start("start_1000", 16'h1000, 1'b1, 1'b0);
    tick("tick_0959", 16'h0959, 1'b1, 1'b0);
    clear("clear_0959");

    // count to done, then done is sticky until clear
    press("k2", 4'd2, 16'h0002);
    start("start_0002", 16'h0002, 1'b1, 1'b0);
    tick("tick_0001", 16'h0001, 1'b1, 1'b0);
    tick("tick_done", 16'h0000, 1'b0, 1'b1);
    tick("tick_in_done", 16'h0000, 1'b0, 1'b1);
    start("start_in_done", 16'h0000, 1'b0, 1'b1);
    clear("clear_done");

    // five keys, invalid digit, held loadn
    press("k5_1", 4'd1, 16'h0001);
    press("k5_2", 4'd2, 16'h0012);
    press("k5_3", 4'd3, 16'h0123);
    press("k5_4", 4'd4, 16'h1234);
    press("k5_5", 4'd5, 16'h2345);
    press("bcd_12", 4'd12, 16'h2345);
    BCD_IN = 4'd6;
    loadn  = 1'b0;
    push_exp("held_first", 16'h3456, 1'b0, 1'b0);
    step();
    check_out();
    repeat (9) step();
    push_exp("held_tenth", 16'h3456, 1'b0, 1'b0);
    check_out();
    loadn = 1'b1;
    step();

    // clear beats a simultaneous load
    BCD_IN = 4'd7; loadn = 1'b0; clearn = 1'b0;
    push_exp("clear_vs_load", 16'h0000, 1'b0, 1'b0);
    step();
    check_out();
    loadn = 1'b1; clearn = 1'b1;
    step();

    // stop together with a tick: pause without decrement
    press("k10a", 4'd1, 16'h0001);
    press("k10b", 4'd0, 16'h0010);
    start("start_0010", 16'h0010, 1'b1, 1'b0);
    stopn = 1'b0; pgt_1hz = 1'b1;
    push_exp("stop_vs_tick", 16'h0010, 1'b0, 1'b0);
    step();
    check_out();
    stopn = 1'b1; pgt_1hz = 1'b0;
    step();
    for (int i = 0; i < 3; i++) tick("tick_paused", 16'h0010, 1'b0, 1'b0);
    start("resume", 16'h0010, 1'b1, 1'b0);
    tick("tick_0009", 16'h0009, 1'b1, 1'b0);
    clear("clear_0009");

    start("start_at_zero", 16'h0000, 1'b0, 1'b0);

    // asynchronous reset mid-run
    press("k5", 4'd5, 16'h0005);
    start("start_0005", 16'h0005, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    push_exp("async_reset", 16'h0000, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    resetn = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
